y_update_writer: RTL and testbench

Read-modify-write engine that owns the Y SRAM while the Y write phase is active. It accepts update requests `{address, 256-bit increment}` from the compute datapath and adds each increment lane-wise, with saturation, into the addressed Y entry. It drives the write-path port group of the Y bus arbiter, reading through read port 1 and writing through the single write port. It raises the write-module enable to the arbiter for the whole phase.

---
 rtl/y_pkg.sv | 26 ++
 rtl/y_update_writer_if.sv | 49 ++++
 rtl/y_lane_sat_add.sv | 32 +++
 rtl/y_update_writer.sv | 127 ++++++++++++
 tb/tb_y_update_writer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y_pkg.sv
// Shared definitions for the Y update writer.
// Contents:
//   ADDR_W, LANES, LANE_W, DATA_W  - Y SRAM geometry
//   IDLE_ADDR                      - address driven when no access is in progress
//   yState_e                       - writer FSM state encoding
//   laneVec_t                      - one Y entry viewed as LANES lanes of LANE_W bits
package y_pkg;

    localparam int ADDR_W = 11;
    localparam int LANES  = 16;
    localparam int LANE_W = 16;
    localparam int DATA_W = LANES * LANE_W;

    localparam logic [ADDR_W-1:0] IDLE_ADDR = 11'h7ff;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } yState_e;

    // Lane 0 is the least-significant LANE_W bits of the entry.
    typedef logic [LANES-1:0][LANE_W-1:0] laneVec_t;

endpackage

// File: rtl/y_update_writer_if.sv
// Port group between the Y update writer, the compute datapath that feeds it
// update requests, and the write-path side of the Y bus arbiter.
//
// Request handshake: a request {in_reqAddr, in_reqData, in_reqLast} transfers
// on every rising clock edge where in_reqValid and op_reqReady are both high.
// The producer may raise in_reqValid at any time; the writer never waits for
// valid before raising ready, and a request that is not accepted has no effect.
//
// Modports:
//   slave  - the writer (takes requests and SRAM read data, drives Y bus)
//   master - the environment (datapath + arbiter/SRAM side)
interface y_update_writer_if
    import y_pkg::*;
#(
    parameter int ADDR_W = y_pkg::ADDR_W,
    parameter int DATA_W = y_pkg::DATA_W
) ();

    // Update request channel
    logic              in_reqValid;
    logic              op_reqReady;
    logic [ADDR_W-1:0] in_reqAddr;
    logic [DATA_W-1:0] in_reqData;
    logic              in_reqLast;

    // Y SRAM write-path port group
    logic [DATA_W-1:0] in_yReadData1;
    logic              op_yWriteModuleEnable;
    logic [ADDR_W-1:0] op_writePathReadAddr1;
    logic [ADDR_W-1:0] op_writePathReadAddr2;
    logic              op_writePathWE;
    logic [ADDR_W-1:0] op_writePathWriteAddr;
    logic [DATA_W-1:0] op_writePathWriteData;

    modport slave (
        input  in_reqValid, in_reqAddr, in_reqData, in_reqLast, in_yReadData1,
        output op_reqReady, op_yWriteModuleEnable, op_writePathReadAddr1,
               op_writePathReadAddr2, op_writePathWE, op_writePathWriteAddr,
               op_writePathWriteData
    );

    modport master (
        output in_reqValid, in_reqAddr, in_reqData, in_reqLast, in_yReadData1,
        input  op_reqReady, op_yWriteModuleEnable, op_writePathReadAddr1,
               op_writePathReadAddr2, op_writePathWE, op_writePathWriteAddr,
               op_writePathWriteData
    );

endinterface

// File: rtl/y_lane_sat_add.sv
// Combinational lane-wise saturating adder for one Y entry.
// Ports:
//   oldVec - current entry value, LANES unsigned lanes
//   incVec - increment, LANES unsigned lanes
//   sumVec - per-lane min(old + inc, all-ones)
//   satAny - high when at least one lane clipped
module y_lane_sat_add #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16
) (
    input  logic [LANES*LANE_W-1:0] oldVec,
    input  logic [LANES*LANE_W-1:0] incVec,
    output logic [LANES*LANE_W-1:0] sumVec,
    output logic                    satAny
);

    logic [LANES-1:0] satLane;

    for (genvar i = 0; i < LANES; i++) begin : gLane
        // One extra bit keeps the carry so overflow is visible.
        logic [LANE_W:0] laneSum;

        assign laneSum = {1'b0, oldVec[i*LANE_W +: LANE_W]}
                       + {1'b0, incVec[i*LANE_W +: LANE_W]};
        assign satLane[i] = laneSum[LANE_W];
        assign sumVec[i*LANE_W +: LANE_W] =
            laneSum[LANE_W] ? {LANE_W{1'b1}} : laneSum[LANE_W-1:0];
    end

    assign satAny = |satLane;

endmodule

// File: rtl/y_update_writer.sv
// Read-modify-write engine that owns the Y SRAM during the Y write phase.
// Each accepted request {addr, increment} reads the entry through read port 1
// in the acceptance cycle and writes the saturated lane-wise sum through the
// write port in the following cycle, sustaining one request per cycle.
// Ports:
//   clock        - sole clock, rising edge
//   reset        - synchronous, active-low
//   in_start     - one-cycle pulse that opens the phase (ignored unless idle)
//   io           - request channel and write-path Y bus group (slave side)
//   op_done      - one-cycle pulse after the last write has been issued
//   op_satFlag   - sticky saturation flag, cleared when a phase opens
//   op_dbgState  - current FSM state, for observation only
module y_update_writer
    import y_pkg::*;
#(
    parameter int                ADDR_W    = y_pkg::ADDR_W,
    parameter int                LANES     = y_pkg::LANES,
    parameter int                LANE_W    = y_pkg::LANE_W,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = y_pkg::IDLE_ADDR
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_start,
    y_update_writer_if.slave     io,
    output logic                 op_done,
    output logic                 op_satFlag,
    output yState_e              op_dbgState
);

    localparam int DATA_W = LANES * LANE_W;

    yState_e state;
    yState_e stateNext;

    logic accept;

    // Stage-2 registers: the request accepted in the previous cycle.
    logic              s2Valid;
    logic [ADDR_W-1:0] s2Addr;
    logic [DATA_W-1:0] s2Inc;

    // Copy of the write issued in the previous cycle. The SRAM returns old
    // data on read-during-write, so a request that reads the entry being
    // written in that same cycle has to take its old value from here.
    logic              fwdValid;
    logic [ADDR_W-1:0] fwdAddr;
    logic [DATA_W-1:0] fwdData;

    logic              fwdHit;
    logic [DATA_W-1:0] oldVec;
    logic [DATA_W-1:0] sumVec;
    logic              satAny;

    assign accept = io.in_reqValid && (state == ST_ACTIVE);

    assign fwdHit = fwdValid && (fwdAddr == s2Addr);
    assign oldVec = fwdHit ? fwdData : io.in_yReadData1;

    y_lane_sat_add #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) uSatAdd (
        .oldVec (oldVec),
        .incVec (s2Inc),
        .sumVec (sumVec),
        .satAny (satAny)
    );

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:   if (in_start) stateNext = ST_ACTIVE;
            ST_ACTIVE: if (accept && io.in_reqLast) stateNext = ST_DRAIN;
            ST_DRAIN:  stateNext = ST_DONE;
            ST_DONE:   stateNext = ST_IDLE;
            default:   stateNext = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        io.op_reqReady           = (state == ST_ACTIVE);
        // Held through DONE so the final write settles through the arbiter.
        io.op_yWriteModuleEnable = (state != ST_IDLE);
        io.op_writePathReadAddr1 = accept ? io.in_reqAddr : IDLE_ADDR;
        io.op_writePathReadAddr2 = IDLE_ADDR;
        io.op_writePathWE        = s2Valid;
        io.op_writePathWriteAddr = s2Valid ? s2Addr : IDLE_ADDR;
        io.op_writePathWriteData = s2Valid ? sumVec : '0;
        op_done                  = (state == ST_DONE);
        op_dbgState              = state;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            s2Valid    <= 1'b0;
            s2Addr     <= IDLE_ADDR;
            s2Inc      <= '0;
            fwdValid   <= 1'b0;
            fwdAddr    <= IDLE_ADDR;
            fwdData    <= '0;
            op_satFlag <= 1'b0;
        end else begin
            state   <= stateNext;
            s2Valid <= accept;
            if (accept) begin
                s2Addr <= io.in_reqAddr;
                s2Inc  <= io.in_reqData;
            end

            fwdValid <= s2Valid;
            if (s2Valid) begin
                fwdAddr <= s2Addr;
                fwdData <= sumVec;
            end

            if (state == ST_IDLE && in_start) begin
                op_satFlag <= 1'b0;
            end else if (s2Valid && satAny) begin
                op_satFlag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_y_update_writer.sv
module tb_y_update_writer;
    import y_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        laneVec_t          init;
        laneVec_t          inc;
        laneVec_t          expData;
        logic              expSat;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic    clock = 1'b0;
    logic    reset = 1'b0;
    logic    in_start = 1'b0;
    logic    op_done;
    logic    op_satFlag;
    yState_e op_dbgState;

    always #5 clock = ~clock;

    y_update_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    y_update_writer #(
        .ADDR_W    (ADDR_W),
        .LANES     (LANES),
        .LANE_W    (LANE_W),
        .IDLE_ADDR (IDLE_ADDR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_start    (in_start),
        .io          (bus.slave),
        .op_done     (op_done),
        .op_satFlag  (op_satFlag),
        .op_dbgState (op_dbgState)
    );

    // ---------------- Y SRAM model (1-cycle read, old data on RDW) ----------------
    logic [DATA_W-1:0] yMem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdData = '0;

    always @(posedge clock) begin
        if (bus.op_writePathWE) yMem[bus.op_writePathWriteAddr] <= bus.op_writePathWriteData;
        rdData <= yMem[bus.op_writePathReadAddr1];
    end
    assign bus.in_yReadData1 = rdData;

    // ---------------- reference model + scoreboard ----------------
    logic [DATA_W-1:0]        refMem [0:(1<<ADDR_W)-1];
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic                     modelSat = 1'b0;
    int                       nChecks = 0;
    int                       nErrors = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] req);
        nChecks++;
        if (act !== req) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic laneVec_t rep(input logic [LANE_W-1:0] v);
        laneVec_t r;
        for (int i = 0; i < LANES; i++) r[i] = v;
        return r;
    endfunction

    // Returns {saturated, sum}.
    function automatic logic [DATA_W:0] modelAdd(input laneVec_t a, input laneVec_t b);
        laneVec_t r;
        logic     s;
        int       t;
        s = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            t = int'(a[i]) + int'(b[i]);
            if (t > 65535) begin
                r[i] = 16'hffff;
                s = 1'b1;
            end else begin
                r[i] = t[LANE_W-1:0];
            end
        end
        return {s, r};
    endfunction

    always @(negedge clock) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (bus.op_writePathWE) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", DATA_W'(bus.op_writePathWE), '0);
            end else begin
                e = exp_q.pop_front();
                check("sb_addr", DATA_W'(bus.op_writePathWriteAddr), DATA_W'(e[ADDR_W+DATA_W-1:DATA_W]));
                check("sb_data", bus.op_writePathWriteData, e[DATA_W-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input laneVec_t v);
        yMem[a]   = v;
        refMem[a] = v;
    endtask

    task automatic idleReq();
        bus.in_reqValid = 1'b0;
        bus.in_reqAddr  = '0;
        bus.in_reqData  = '0;
        bus.in_reqLast  = 1'b0;
    endtask

    task automatic startPhase();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        modelSat = 1'b0;
        check("start_sat_cleared", DATA_W'(op_satFlag), '0);
        check("start_state", DATA_W'(op_dbgState), DATA_W'(ST_ACTIVE));
    endtask

    // Presents one request for one cycle; expWe is the write enable expected
    // in that same cycle (high when the previous cycle also accepted).
    task automatic sendReq(input logic [ADDR_W-1:0] a, input laneVec_t inc,
                           input logic last, input logic expWe);
        logic [DATA_W:0] r;
        bus.in_reqValid = 1'b1;
        bus.in_reqAddr  = a;
        bus.in_reqData  = inc;
        bus.in_reqLast  = last;
        r = modelAdd(refMem[a], inc);
        refMem[a] = r[DATA_W-1:0];
        modelSat  = modelSat | r[DATA_W];
        exp_q.push_back({a, r[DATA_W-1:0]});
        @(negedge clock);
        check("req_ready", DATA_W'(bus.op_reqReady), DATA_W'(1));
        check("read_addr1", DATA_W'(bus.op_writePathReadAddr1), DATA_W'(a));
        check("we_pipelined", DATA_W'(bus.op_writePathWE), DATA_W'(expWe));
        tick();
    endtask

    // Called in the cycle after the last request was accepted.
    task automatic finishPhase(input logic useData, input logic [ADDR_W-1:0] a,
                               input laneVec_t d, input logic expSat);
        idleReq();
        @(negedge clock);
        check("drain_state", DATA_W'(op_dbgState), DATA_W'(ST_DRAIN));
        check("drain_we", DATA_W'(bus.op_writePathWE), DATA_W'(1));
        check("drain_enable", DATA_W'(bus.op_yWriteModuleEnable), DATA_W'(1));
        check("drain_no_done", DATA_W'(op_done), '0);
        if (useData) begin
            check("vec_waddr", DATA_W'(bus.op_writePathWriteAddr), DATA_W'(a));
            check("vec_wdata", bus.op_writePathWriteData, d);
        end
        tick();
        @(negedge clock);
        check("done_pulse", DATA_W'(op_done), DATA_W'(1));
        check("done_enable", DATA_W'(bus.op_yWriteModuleEnable), DATA_W'(1));
        check("done_sat", DATA_W'(op_satFlag), DATA_W'(expSat));
        check("done_waddr_idle", DATA_W'(bus.op_writePathWriteAddr), DATA_W'(IDLE_ADDR));
        check("done_wdata_zero", bus.op_writePathWriteData, '0);
        tick();
        @(negedge clock);
        check("post_done_low", DATA_W'(op_done), '0);
        check("post_enable_low", DATA_W'(bus.op_yWriteModuleEnable), '0);
        check("post_state", DATA_W'(op_dbgState), DATA_W'(ST_IDLE));
        tick();
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[6];

    initial begin
        laneVec_t t0, t1, t2;
        logic     prevSat;

        idleReq();

        // Vector table: {addr, initial entry, increment, expected write, expected sat}
        vecs[0] = '{addr: 11'd5,   init: rep(16'd10),    inc: rep(16'd3),    expData: rep(16'd13),   expSat: 1'b0};
        t0 = rep(16'h0000); t0[0] = 16'hfff0;
        t1 = rep(16'h0001); t1[0] = 16'h0020;
        t2 = rep(16'h0001); t2[0] = 16'hffff;
        vecs[1] = '{addr: 11'h100, init: t0,             inc: t1,            expData: t2,            expSat: 1'b1};
        vecs[2] = '{addr: 11'h7fe, init: rep(16'hffff),  inc: rep(16'h0000), expData: rep(16'hffff), expSat: 1'b0};
        vecs[3] = '{addr: 11'd0,   init: rep(16'h8000),  inc: rep(16'h7fff), expData: rep(16'hffff), expSat: 1'b0};
        vecs[4] = '{addr: 11'd7,   init: rep(16'h8000),  inc: rep(16'h8000), expData: rep(16'hffff), expSat: 1'b1};
        for (int i = 0; i < LANES; i++) begin
            t0[i] = 16'(i * 4096);
            t2[i] = 16'(i * 4096 + 16'h0fff);
        end
        vecs[5] = '{addr: 11'd1,   init: t0,             inc: rep(16'h0fff), expData: t2,            expSat: 1'b0};

        // Reset state
        tick();
        tick();
        @(negedge clock);
        check("rst_state", DATA_W'(op_dbgState), DATA_W'(ST_IDLE));
        check("rst_we", DATA_W'(bus.op_writePathWE), '0);
        check("rst_enable", DATA_W'(bus.op_yWriteModuleEnable), '0);
        check("rst_ready", DATA_W'(bus.op_reqReady), '0);
        check("rst_done", DATA_W'(op_done), '0);
        check("rst_sat", DATA_W'(op_satFlag), '0);
        check("rst_raddr1", DATA_W'(bus.op_writePathReadAddr1), DATA_W'(IDLE_ADDR));
        check("rst_raddr2", DATA_W'(bus.op_writePathReadAddr2), DATA_W'(IDLE_ADDR));
        check("rst_waddr", DATA_W'(bus.op_writePathWriteAddr), DATA_W'(IDLE_ADDR));
        check("rst_wdata", bus.op_writePathWriteData, '0);
        tick();
        reset = 1'b1;
        tick();

        // Request held valid while idle: never ready, never written
        bus.in_reqValid = 1'b1;
        bus.in_reqAddr  = 11'd5;
        bus.in_reqData  = rep(16'd1);
        bus.in_reqLast  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("idle_ready", DATA_W'(bus.op_reqReady), '0);
            check("idle_we", DATA_W'(bus.op_writePathWE), '0);
            check("idle_raddr1", DATA_W'(bus.op_writePathReadAddr1), DATA_W'(IDLE_ADDR));
            tick();
        end
        idleReq();
        check("idle_state", DATA_W'(op_dbgState), DATA_W'(ST_IDLE));

        // Table-driven single-update phases
        prevSat = 1'b0;
        for (int v = 0; v < 6; v++) begin
            check("sat_sticky_idle", DATA_W'(op_satFlag), DATA_W'(prevSat));
            preload(vecs[v].addr, vecs[v].init);
            startPhase();
            sendReq(vecs[v].addr, vecs[v].inc, 1'b1, 1'b0);
            finishPhase(1'b1, vecs[v].addr, vecs[v].expData, vecs[v].expSat);
            check("vec_mem", yMem[vecs[v].addr], vecs[v].expData);
            prevSat = vecs[v].expSat;
        end

        // Back-to-back same address: needs forwarding
        preload(11'd9, rep(16'd0));
        startPhase();
        sendReq(11'd9, rep(16'd1), 1'b0, 1'b0);
        sendReq(11'd9, rep(16'd1), 1'b0, 1'b1);
        sendReq(11'd9, rep(16'd1), 1'b1, 1'b1);
        finishPhase(1'b0, '0, '0, modelSat);
        check("b2b_mem9", yMem[9], rep(16'd3));

        // Alternating addresses: no false forwarding
        preload(11'd2, rep(16'd0));
        preload(11'd3, rep(16'd0));
        startPhase();
        sendReq(11'd2, rep(16'd1), 1'b0, 1'b0);
        sendReq(11'd3, rep(16'd1), 1'b0, 1'b1);
        sendReq(11'd2, rep(16'd1), 1'b0, 1'b1);
        sendReq(11'd3, rep(16'd1), 1'b1, 1'b1);
        finishPhase(1'b0, '0, '0, modelSat);
        check("alt_mem2", yMem[2], rep(16'd2));
        check("alt_mem3", yMem[3], rep(16'd2));

        // Start during ACTIVE is ignored: the sticky flag must survive it
        preload(11'd40, rep(16'hfff0));
        preload(11'd41, rep(16'd0));
        startPhase();
        sendReq(11'd40, rep(16'h0020), 1'b0, 1'b0);
        idleReq();
        tick();
        in_start = 1'b1;
        @(negedge clock);
        check("mid_sat_set", DATA_W'(op_satFlag), DATA_W'(1));
        tick();
        in_start = 1'b0;
        @(negedge clock);
        check("mid_start_sat", DATA_W'(op_satFlag), DATA_W'(1));
        check("mid_start_state", DATA_W'(op_dbgState), DATA_W'(ST_ACTIVE));
        check("mid_start_ready", DATA_W'(bus.op_reqReady), DATA_W'(1));
        tick();
        sendReq(11'd41, rep(16'd1), 1'b1, 1'b0);
        finishPhase(1'b0, '0, '0, modelSat);
        check("mid_mem40", yMem[40], rep(16'hffff));

        // Reset mid-phase: request presented in the cycle reset is sampled low
        preload(11'd60, rep(16'hffff));
        preload(11'd61, rep(16'd0));
        startPhase();
        sendReq(11'd60, rep(16'd1), 1'b0, 1'b0);
        idleReq();
        tick();
        bus.in_reqValid = 1'b1;
        bus.in_reqAddr  = 11'd61;
        bus.in_reqData  = rep(16'd7);
        bus.in_reqLast  = 1'b1;
        reset = 1'b0;
        @(negedge clock);
        check("pre_rst_sat", DATA_W'(op_satFlag), DATA_W'(1));
        tick();
        @(negedge clock);
        check("mrst_we", DATA_W'(bus.op_writePathWE), '0);
        check("mrst_state", DATA_W'(op_dbgState), DATA_W'(ST_IDLE));
        check("mrst_enable", DATA_W'(bus.op_yWriteModuleEnable), '0);
        check("mrst_sat", DATA_W'(op_satFlag), '0);
        check("mrst_waddr", DATA_W'(bus.op_writePathWriteAddr), DATA_W'(IDLE_ADDR));
        check("mrst_wdata", bus.op_writePathWriteData, '0);
        check("mrst_raddr1", DATA_W'(bus.op_writePathReadAddr1), DATA_W'(IDLE_ADDR));
        tick();
        idleReq();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("mrst_no_done", DATA_W'(op_done), '0);
            check("mrst_no_we", DATA_W'(bus.op_writePathWE), '0);
            tick();
        end
        check("mrst_mem61", yMem[61], rep(16'd0));

        check("sb_empty", DATA_W'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
